// File: rtl/op_io_ctrl.sv
// Sequences core input/output byte ops against host streams; output bytes buffered in a small FIFO.
// Optional input-wait timeout enabled by defining IO_TIMEOUT_EN.
module op_io_ctrl #(
  parameter int DATA_BITWIDTH  = 8,
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op_in_req,
  input  logic                     op_out_req,
  input  logic [DATA_BITWIDTH-1:0] op_out_data,
  output logic [DATA_BITWIDTH-1:0] op_in_data,
  output logic                     op_done,
  output logic                     op_busy,
  output logic                     op_timeout,
  input  logic                     host_in_valid,
  input  logic [DATA_BITWIDTH-1:0] host_in_data,
  output logic                     host_in_ready,
  output logic                     host_out_valid,
  output logic [DATA_BITWIDTH-1:0] host_out_data,
  input  logic                     host_out_ready,
  output logic                     flag_op_input_done,
  output logic                     flag_op_output_ready
);

  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_IN_WAIT, S_OUT_WAIT, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [DATA_BITWIDTH-1:0] mem_q [OUT_FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DATA_BITWIDTH-1:0] in_data_q, in_data_d;
  logic                     was_in_q, was_in_d;
  logic                     out_rdy_q;
  logic                     push, pop, full, empty, in_hs, tmo_hit;

  assign full  = (count_q == CNT_W'(OUT_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign pop   = !empty && host_out_ready;

  // Input is only accepted once every previously issued output byte has left.
  assign host_in_ready = (state_q == S_IN_WAIT) && empty;
  assign in_hs         = host_in_valid && host_in_ready;

`ifdef IO_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_q;

  assign tmo_hit = (state_q == S_IN_WAIT) && !in_hs &&
                   (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_IN_WAIT) ? tmo_cnt_q + TMO_W'(1) : '0;
      tmo_q     <= tmo_hit;
    end
  end

  assign op_timeout = tmo_q;
`else
  assign tmo_hit    = 1'b0;
  assign op_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    in_data_d = in_data_q;
    was_in_d  = was_in_q;
    case (state_q)
      S_IDLE: begin
        if (op_in_req) begin
          state_d = S_IN_WAIT;
        end else if (op_out_req) begin
          was_in_d = 1'b0;
          if (!full) begin
            push    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_OUT_WAIT;
          end
        end
      end
      S_IN_WAIT: begin
        if (in_hs) begin
          in_data_d = host_in_data;
          was_in_d  = 1'b1;
          state_d   = S_DONE;
        end else if (tmo_hit) begin
          in_data_d = '0;
          was_in_d  = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_OUT_WAIT: begin
        if (!full) begin
          push    = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      in_data_q <= '0;
      was_in_q  <= 1'b0;
      out_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      in_data_q <= in_data_d;
      was_in_q  <= was_in_d;
      out_rdy_q <= !empty;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= op_out_data;
  end

  assign host_out_valid       = !empty;
  assign host_out_data        = empty ? '0 : mem_q[rd_ptr_q];
  assign op_in_data           = in_data_q;
  assign op_done              = (state_q == S_DONE);
  assign op_busy              = (state_q != S_IDLE);
  assign flag_op_input_done   = op_done && was_in_q;
  assign flag_op_output_ready = out_rdy_q;

endmodule

// File: tb/tb_op_io_ctrl.sv
// Directed self-checking bench for op_io_ctrl: vector table of single ops plus corner-case sequences.
module tb_op_io_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       op_in_req, op_out_req;
  logic [7:0] op_out_data, op_in_data;
  logic       op_done, op_busy, op_timeout;
  logic       host_in_valid, host_in_ready;
  logic [7:0] host_in_data, host_out_data;
  logic       host_out_valid, host_out_ready;
  logic       flag_op_input_done, flag_op_output_ready;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int tmo_cnt  = 0;
  logic [7:0] popped [$];

  op_io_ctrl #(.DATA_BITWIDTH(8), .OUT_FIFO_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_in_req(op_in_req), .op_out_req(op_out_req), .op_out_data(op_out_data),
    .op_in_data(op_in_data), .op_done(op_done), .op_busy(op_busy), .op_timeout(op_timeout),
    .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
    .host_out_valid(host_out_valid), .host_out_data(host_out_data), .host_out_ready(host_out_ready),
    .flag_op_input_done(flag_op_input_done), .flag_op_output_ready(flag_op_output_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && host_out_valid && host_out_ready) popped.push_back(host_out_data);
    if (op_done) done_cnt++;
    if (op_timeout) tmo_cnt++;
  end

  typedef struct {
    logic       is_in;
    logic [7:0] ob;
    logic [7:0] ib;
    int         lat;
    logic [7:0] exp_in;
    logic       exp_rdy_after;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns edges until op_done is seen, or -1 if the budget runs out.
  task automatic wait_done(output int n);
    n = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (op_done) begin
        n = c;
        break;
      end
    end
  endtask

  function automatic logic [31:0] pop_at(input int j);
    return (j < popped.size()) ? 32'(popped[j]) : 32'hDEAD;
  endfunction

  int n;
  int snap;
  int viol;

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 8'h11, 1, 8'h00, 1'b1};
    tbl[1] = '{1'b1, 8'h00, 8'h3C, 2, 8'h3C, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 8'h22, 1, 8'h3C, 1'b1};
    tbl[3] = '{1'b1, 8'h00, 8'hFF, 2, 8'hFF, 1'b0};
    tbl[4] = '{1'b0, 8'hFF, 8'h33, 1, 8'hFF, 1'b1};
    tbl[5] = '{1'b1, 8'h00, 8'h00, 2, 8'h00, 1'b0};

    rst_n = 1'b0;
    op_in_req = 0; op_out_req = 0; op_out_data = 0;
    host_in_valid = 0; host_in_data = 0; host_out_ready = 0;
    step(3);
    rst_n = 1'b1;
    step(2);
    check("rst_busy", op_busy, 0);
    check("rst_done", op_done, 0);
    check("rst_timeout", op_timeout, 0);
    check("rst_out_valid", host_out_valid, 0);
    check("rst_out_data", host_out_data, 0);
    check("rst_in_ready", host_in_ready, 0);
    check("rst_in_data", op_in_data, 0);
    check("rst_flags", {flag_op_input_done, flag_op_output_ready}, 0);

    // Single ops from IDLE with the host always ready.
    host_out_ready = 1; host_in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      popped.delete();
      host_in_data = tbl[i].ib;
      op_out_data  = tbl[i].ob;
      if (tbl[i].is_in) op_in_req = 1; else op_out_req = 1;
      wait_done(n);
      check($sformatf("vec%0d_lat", i), n, tbl[i].lat);
      check($sformatf("vec%0d_in_data", i), op_in_data, tbl[i].exp_in);
      check($sformatf("vec%0d_in_flag", i), flag_op_input_done, tbl[i].is_in);
      check($sformatf("vec%0d_busy", i), op_busy, 1);
      check($sformatf("vec%0d_rdy_done", i), flag_op_output_ready, 0);
      op_in_req = 0; op_out_req = 0;
      step(1);
      check($sformatf("vec%0d_idle", i), op_busy, 0);
      check($sformatf("vec%0d_rdy_after", i), flag_op_output_ready, tbl[i].exp_rdy_after);
      check($sformatf("vec%0d_npop", i), popped.size(), tbl[i].is_in ? 0 : 1);
      if (!tbl[i].is_in) check($sformatf("vec%0d_pop", i), pop_at(0), tbl[i].ob);
    end

    // Fill the FIFO, then stall a fifth request until the host drains.
    host_out_ready = 0; host_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      op_out_data = 8'h41 + 8'(i);
      op_out_req = 1;
      wait_done(n);
      check($sformatf("fill%0d_lat", i), n, 1);
      op_out_req = 0;
      step(1);
    end
    snap = done_cnt;
    op_out_data = 8'h45;
    op_out_req = 1;
    step(6);
    check("full_no_done", done_cnt - snap, 0);
    check("full_busy", op_busy, 1);
    check("full_head", host_out_data, 8'h41);
    check("full_rdy", flag_op_output_ready, 1);
    popped.delete();
    host_out_ready = 1;
    wait_done(n);
    check("full_release_lat", n, 2);
    op_out_req = 0;
    step(8);
    check("full_npop", popped.size(), 5);
    for (int j = 0; j < 5; j++) check($sformatf("full_pop%0d", j), pop_at(j), 8'h41 + 8'(j));

    // Input must wait for pending output to drain.
    host_out_ready = 0;
    op_out_data = 8'h55;
    op_out_req = 1;
    wait_done(n);
    check("drain_out_lat", n, 1);
    op_out_req = 0;
    step(1);
    host_in_valid = 1; host_in_data = 8'h7F;
    op_in_req = 1;
    viol = 0;
    for (int c = 0; c < 5; c++) begin
      step(1);
      if (host_in_ready || op_done) viol++;
    end
    check("drain_in_blocked", viol, 0);
    popped.delete();
    host_out_ready = 1;
    wait_done(n);
    check("drain_in_lat", n, 2);
    check("drain_in_data", op_in_data, 8'h7F);
    check("drain_in_flag", flag_op_input_done, 1);
    check("drain_pop", pop_at(0), 8'h55);
    op_in_req = 0;
    step(1);

    // Both requests at once: input first, output stays pending.
    host_in_data = 8'h12; op_out_data = 8'h66;
    op_in_req = 1; op_out_req = 1;
    popped.delete();
    wait_done(n);
    check("both_in_lat", n, 2);
    check("both_in_flag", flag_op_input_done, 1);
    check("both_in_data", op_in_data, 8'h12);
    check("both_no_push", host_out_valid, 0);
    op_in_req = 0;
    wait_done(n);
    check("both_out_lat", n, 2);
    check("both_out_flag", flag_op_input_done, 0);
    op_out_req = 0;
    step(1);
    check("both_pop", pop_at(0), 8'h66);

    // Reset while waiting for input with two bytes buffered.
    host_out_ready = 0; host_in_valid = 0;
    for (int i = 0; i < 2; i++) begin
      op_out_data = 8'h01 + 8'(i);
      op_out_req = 1;
      wait_done(n);
      op_out_req = 0;
      step(1);
    end
    op_in_req = 1;
    step(3);
    check("rstmid_busy_before", op_busy, 1);
    check("rstmid_valid_before", host_out_valid, 1);
    snap = done_cnt;
    rst_n = 0;
    op_in_req = 0;
    #1;
    check("rstmid_busy", op_busy, 0);
    check("rstmid_valid", host_out_valid, 0);
    check("rstmid_in_data", op_in_data, 0);
    step(3);
    rst_n = 1;
    step(3);
    check("rstmid_no_done", done_cnt - snap, 0);
    check("rstmid_idle", {op_busy, host_out_valid, flag_op_output_ready}, 0);

`ifdef IO_TIMEOUT_EN
    host_in_valid = 1; host_in_data = 8'h99;
    op_in_req = 1;
    wait_done(n);
    check("tmo_pre_data", op_in_data, 8'h99);
    op_in_req = 0;
    step(1);
    host_in_valid = 0;
    op_in_req = 1;
    wait_done(n);
    check("tmo_lat", n, 9);
    check("tmo_pulse", op_timeout, 1);
    check("tmo_in_data", op_in_data, 0);
    check("tmo_in_flag", flag_op_input_done, 1);
    op_in_req = 0;
    step(1);
    check("tmo_pulse_end", op_timeout, 0);
`else
    snap = done_cnt;
    host_in_valid = 0; host_in_data = 8'hC3;
    op_in_req = 1;
    step(20);
    check("notmo_waiting", done_cnt - snap, 0);
    check("notmo_ready", host_in_ready, 1);
    host_in_valid = 1;
    wait_done(n);
    check("notmo_lat", n, 1);
    check("notmo_data", op_in_data, 8'hC3);
    op_in_req = 0;
    step(1);
    check("notmo_never", tmo_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/op_io_ctrl.md
# op_io_ctrl

Sequences the BXU core's input and output operations against the external host byte streams. It stalls the core while an input byte is awaited or the output buffer is full, and buffers output bytes in a small FIFO. It generates the `flag_op_input_done` and `flag_op_output_ready` flags consumed by `op_io`. It sits between the execution core's op decode and the host-facing I/O pins.

## Interface
- `DATA_BITWIDTH`, 8, I/O byte width
- `OUT_FIFO_DEPTH`, 4, output FIFO entries; power of two, ≥2
- `TIMEOUT_CYCLES`, 1024, input wait limit (only with `IO_TIMEOUT_EN`)

- `clk` in 1 — system clock, all logic on posedge
- `rst_n` in 1 — asynchronous, active-low reset
- `op_in_req` in 1 — core requests one input byte; level, held until `op_done`
- `op_out_req` in 1 — core requests one output byte; level, held until `op_done`
- `op_out_data` in DATA_BITWIDTH — byte to output; sampled with `op_out_req`
- `op_in_data` out DATA_BITWIDTH — last captured input byte
- `op_done` out 1 — one-cycle pulse, current op complete
- `op_busy` out 1 — high in any state except IDLE
- `op_timeout` out 1 — one-cycle pulse with `op_done` on input timeout
- `host_in_valid` in 1 — host offers input byte
- `host_in_data` in DATA_BITWIDTH — input byte
- `host_in_ready` out 1 — controller accepts input byte
- `host_out_valid` out 1 — output FIFO non-empty
- `host_out_data` out DATA_BITWIDTH — FIFO head byte
- `host_out_ready` in 1 — host consumes head byte
- `flag_op_input_done` out 1 — pulse, input op complete (to `op_io`)
- `flag_op_output_ready` out 1 — level, output byte pending (to `op_io`)

## Operation
- FSM states: IDLE, IN_WAIT, OUT_WAIT, DONE. Reset → IDLE.
- **IDLE**
  - If `op_in_req`, go to IN_WAIT. Input has priority when both requests are high; the output request stays pending.
  - Else if `op_out_req` and the FIFO is not full, push `op_out_data` and go to DONE.
  - Else if `op_out_req` and the FIFO is full, go to OUT_WAIT.
- **IN_WAIT**
  - `host_in_ready = 1` only when the output FIFO is empty. All prior output drains before input is accepted.
  - On `host_in_valid & host_in_ready`, register `host_in_data` into `op_in_data` and go to DONE.
- **OUT_WAIT**
  - When the FIFO is not full, push `op_out_data` and go to DONE.
- **DONE**
  - `op_done = 1` for this one cycle. `flag_op_input_done = 1` if the completed op was an input.
  - Go to IDLE unconditionally. Requests are ignored in DONE; the core drops its request at the edge ending DONE.
- **FIFO**
  - Circular buffer with pointers of width log2(OUT_FIFO_DEPTH) and a count of log2(OUT_FIFO_DEPTH)+1 bits. Pointers wrap modulo depth.
  - Pop occurs on `host_out_valid & host_out_ready`.
  - Push is only permitted when not full (registered count), so no overflow is possible.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop from empty cannot occur because valid is low.
- `flag_op_output_ready` is a registered copy of (count ≠ 0).
- `op_in_data` holds its value until the next capture.

## Timing
- Reset values:
  - all outputs 0
  - FIFO empty, pointers 0
  - `op_in_data` = 0
  - state IDLE
- Reset mid-operation aborts the op and discards FIFO contents. No `op_done` is issued.
- Output latency with space: request seen at edge k → DONE during cycle k+1 (`op_done` high). The byte is visible on `host_out_data` from cycle k+1 if the FIFO was empty.
- Output latency when full: DONE occurs the cycle after the first pop that frees a slot.
- Input latency: handshake at edge k → `op_done` and the new `op_in_data` both valid during cycle k+1.
- `op_busy` is registered from state; it is high in IN_WAIT, OUT_WAIT and DONE.
- `flag_op_output_ready` lags the FIFO count by one cycle.

## Configuration
- `IO_TIMEOUT_EN` defined:
  - A cycle counter resets on entry to IN_WAIT and increments each IN_WAIT cycle.
  - When it reaches TIMEOUT_CYCLES−1 with no handshake, `op_in_data` is set to 0, the FSM goes to DONE, and `op_timeout` pulses with `op_done`.
  - A handshake in that same cycle wins: data is captured and there is no timeout.
- Not defined: no counter is present, `op_timeout` is tied 0, and IN_WAIT waits indefinitely.

## Test plan
- Reset then idle: all outputs 0, `op_busy` = 0, `host_out_valid` = 0.
- Four back-to-back `op_out_req` (0x41..0x44) with `host_out_ready` = 0: four `op_done` pulses. A fifth request stalls in OUT_WAIT. Raising `host_out_ready` pops 0x41 first, then the fifth op completes one cycle later.
- Output 0x55 pending with `host_out_ready` = 0, then `op_in_req`: `host_in_ready` stays 0 until 0x55 is popped. Input 0x7F is then captured and `op_in_data` = 0x7F together with `op_done` and `flag_op_input_done`.
- `op_in_req` and `op_out_req` high together in IDLE: the input completes first, then the output op completes.
- Reset asserted in IN_WAIT with 2 bytes buffered: FIFO empties, FSM returns to IDLE, and no `op_done` is issued.
- With `IO_TIMEOUT_EN` and TIMEOUT_CYCLES = 8, no host input: `op_done` and `op_timeout` pulse, `op_in_data` = 0 exactly 8 cycles after IN_WAIT entry.
